fp_add_result_stage: RTL
========================

FP_ADD_RESULT_STAGE -- requirements
Module: fp_add_result_stage

Interface
REQ-001 DEPTH, 2, number of result entries buffered; fixed at 2 for this revision.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  adder result valid this cycle.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 fp_result  input  32  IEEE-754 single result from the FP adder.
REQ-007 overflow  input  1  adder overflow flag for fp_result.
REQ-008 underflow  input  1  adder underflow flag for fp_result.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  consumer accepts head entry.
REQ-011 out_result  output  32  head entry result word.
REQ-012 out_class  output  3  head entry class: 0 zero, 1 subnormal, 2 normal, 3 infinity, 4 quiet NaN, 5 signaling NaN.
REQ-013 out_flags  output  2  head entry {overflow, underflow}.
REQ-014 sticky_flags  output  3  accumulated {nan_seen, overflow, underflow}.
REQ-015 flags_clear  input  1  clears sticky_flags.
REQ-016 count  output  2  number of buffered entries, 0..2.
REQ-017 op_count  output  16  accepted-result counter, saturating.

Function
REQ-018 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-019 in_ready SHALL be 1 exactly when count < 2; it SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL be 1 exactly when count > 0; outputs out_result/out_class/out_flags come from registered head entry only.
REQ-021 Latency: a result pushed in cycle N is visible at outputs in cycle N+1 at the earliest; there is no combinational bypass.
REQ-022 Order: entries leave in push order; storage is a 2-entry circular buffer with 1-bit write and read pointers wrapping 1->0.
REQ-023 Push and pop in same cycle: count unchanged, both pointers advance.
REQ-024 Full (count=2): in_valid ignored, no state change from input side; pop alone decrements count.
REQ-025 Empty (count=0): out_ready ignored; out_result/out_class/out_flags hold last values.
REQ-026 Classification computed at push from fp_result: exp=0,frac=0 -> 0; exp=0,frac!=0 -> 1; exp 1..254 -> 2; exp=255,frac=0 -> 3; exp=255,frac[22]=1 -> 4; exp=255,frac[22]=0,frac!=0 -> 5; sign ignored.
REQ-027 sticky_flags on push: overflow bit |= overflow, underflow bit |= underflow, nan_seen |= (class 4 or 5); update visible next cycle.
REQ-028 flags_clear without push: sticky_flags -> 0 next cycle.
REQ-029 flags_clear with push same cycle: sticky_flags -> flags of that push only (new event wins over clear).
REQ-030 op_count increments by 1 per push; saturates at 16'hFFFF, never wraps.
REQ-031 Input fields are sampled only on push; values with in_valid=0 have no effect.

Reset
REQ-032 rst asserted: count=0, pointers=0, out_valid=0, in_ready=0 while rst high, sticky_flags=0, op_count=0, out_result=0, out_class=0, out_flags=0, asynchronously.
REQ-033 in_ready SHALL rise to 1 in the first cycle after rst deasserts.
REQ-034 rst mid-operation discards all buffered entries; no entry is presented after reset release.

Verification
REQ-035 Push 32'h3F800000 (of=0,uf=0), out_ready=1 -> next cycle out_valid=1, out_result=3F800000, out_class=2, then count returns 0; op_count=1.
REQ-036 out_ready=0, push 32'h7F800000 then 32'h000A0000 -> count=2, in_ready=0; third push ignored; release out_ready -> outputs 7F800000 class 3, then 000A0000 class 1.
REQ-037 Full buffer, in_valid=1 and out_ready=1 same cycle -> pop only, count 2->1; next cycle push accepted, count=2.
REQ-038 Push 32'h7FC00000, then 32'h7F800001 with overflow=1 -> classes 4 and 5; sticky_flags=3'b110; assert flags_clear alone -> 3'b000; flags_clear with push underflow=1 -> 3'b001.
REQ-039 rst asserted with count=2 -> out_valid=0, count=0, sticky_flags=0 immediately; after release in_ready=1, no stale entry emitted.
REQ-040 Preload op_count near limit by 65537 pushes -> op_count=16'hFFFF, holds on further pushes.

Source files
------------

// File: rtl/fp_add_result_stage.sv
`default_nettype none
// ============================================================================
// fp_add_result_stage : 2-entry result buffer behind the FP adder with
// operand classification, sticky exception flags and a saturating op counter.
// Revision 1.0
// ============================================================================
module fp_add_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_result,
  input  logic        overflow,
  input  logic        underflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_class,
  output logic [1:0]  out_flags,
  output logic [2:0]  sticky_flags,
  input  logic        flags_clear,
  output logic [1:0]  count,
  output logic [15:0] op_count
);

  localparam logic [1:0]  FULL_COUNT = 2'(DEPTH);
  localparam logic [15:0] OPS_MAX    = 16'hFFFF;
  localparam logic [2:0]  CLS_ZERO   = 3'd0;
  localparam logic [2:0]  CLS_SUB    = 3'd1;
  localparam logic [2:0]  CLS_NORM   = 3'd2;
  localparam logic [2:0]  CLS_INF    = 3'd3;
  localparam logic [2:0]  CLS_QNAN   = 3'd4;
  localparam logic [2:0]  CLS_SNAN   = 3'd5;

  // Entry layout: {result[31:0], class[2:0], overflow, underflow}
  typedef logic [36:0] entry_t;

  function automatic logic [2:0] classify(input logic [31:0] w);
    logic [2:0] cls;
    if (w[30:23] == 8'd0)
      cls = (w[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB;
    else if (w[30:23] != 8'hFF)
      cls = CLS_NORM;
    else if (w[22:0] == 23'd0)
      cls = CLS_INF;
    else if (w[22])
      cls = CLS_QNAN;
    else
      cls = CLS_SNAN;
    return cls;
  endfunction

  entry_t       mem_q [DEPTH];
  entry_t       mem_d [DEPTH];
  entry_t       head_q, head_d;
  entry_t       new_entry;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic [2:0]   sticky_q, sticky_d;
  logic [15:0]  ops_q, ops_d;
  logic         push, pop;
  logic [2:0]   new_class;

  assign in_ready     = ~rst & (count_q < FULL_COUNT);
  assign out_valid    = (count_q != 2'd0);
  assign out_result   = head_q[36:5];
  assign out_class    = head_q[4:2];
  assign out_flags    = head_q[1:0];
  assign sticky_flags = sticky_q;
  assign count        = count_q;
  assign op_count     = ops_q;

  always_comb begin
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    new_class = classify(fp_result);
    new_entry = {fp_result, new_class, overflow, underflow};

    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};

    mem_d = mem_q;
    if (push)
      mem_d[wr_ptr_q] = new_entry;

    // Output registers track the next head; they hold when the buffer drains.
    head_d = head_q;
    if (count_d != 2'd0)
      head_d = mem_d[rd_ptr_d];

    // A push in the same cycle as a clear still records its own events.
    sticky_d = sticky_q;
    if (push)
      sticky_d = (flags_clear ? 3'b000 : sticky_q) |
                 {(new_class == CLS_QNAN) || (new_class == CLS_SNAN), overflow, underflow};
    else if (flags_clear)
      sticky_d = 3'b000;

    ops_d = ops_q;
    if (push && (ops_q != OPS_MAX))
      ops_d = ops_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      head_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sticky_q <= 3'b000;
      ops_q    <= 16'd0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      ops_q    <= ops_d;
    end
  end

endmodule
`default_nettype wire
